// File: rtl/adda_ser16_rx_if.sv
// Bundle of the ADDA serial link pins, the error-clear strobe and the decoded outputs.
// The receiver takes the slave view; whoever drives the link takes the master view.
interface adda_ser16_rx_if;
    logic         load;
    logic         sclk;
    logic         sdo;
    logic         clr_err;
    logic         word_valid;
    logic [15:0]  word_data;
    logic [127:0] ch16_data;
    logic         upd1595;
    logic [63:0]  ch8_data;
    logic         upd595;
    logic         frame_err;
    logic         pattern_err;

    modport master (
        output load, sclk, sdo, clr_err,
        input  word_valid, word_data, ch16_data, upd1595, ch8_data, upd595,
               frame_err, pattern_err
    );

    modport slave (
        input  load, sclk, sdo, clr_err,
        output word_valid, word_data, ch16_data, upd1595, ch8_data, upd595,
               frame_err, pattern_err
    );
endinterface

// File: rtl/adda_ser16_rx.sv
// Oversampling receiver for the ADDA LD_W/CLK_W/DATA_W link: frames 16-bit words,
// checks the tail pattern and rebuilds the 1595/595 latch images from the bit lanes.
//
// state  | meaning
// IDLE   | waiting for a load falling edge (only once armed after reset)
// SHIFT  | frame open, shifting sdo on each sclk rising edge
// CHECK  | frame closed, checking bit count and tail pattern
// DECODE | word accepted, applying the lane decode
module adda_ser16_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [4:0] TAIL_PAT    = 5'b10101
) (
    input logic             clkin,
    input logic             rst_n,
    adda_ser16_rx_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DECODE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] load_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdo_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   load_s, sclk_s, sdo_s;
    logic                   load_q, sclk_q;
    logic                   armed;
    logic                   load_fall, load_rise, sclk_rise;
    logic [15:0]            rx_sr;
    logic [4:0]             bit_cnt;
    logic [7:0][15:0]       ch_sr;
    logic [7:0][15:0]       ch_shift;
    logic [63:0]            ch8_next;
    logic                   prev_sclk16, prev_ld1595, prev_ld595;
    logic                   s16_rise, l1595_fall, l595_rise;

    assign load_s = load_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdo_s  = sdo_sync[SYNC_STAGES-1];

    // A low load seen right after reset is stale: accept falls only after load was seen high.
    assign load_fall = armed & load_q & ~load_s;
    assign load_rise = ~load_q & load_s;
    assign sclk_rise = ~sclk_q & sclk_s;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            load_sync <= '1;
            sclk_sync <= '0;
            sdo_sync  <= '0;
            fill      <= '0;
            load_q    <= 1'b1;
            sclk_q    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            load_sync <= {load_sync[SYNC_STAGES-2:0], bus.load};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            sdo_sync  <= {sdo_sync[SYNC_STAGES-2:0], bus.sdo};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            load_q    <= load_s;
            sclk_q    <= sclk_s;
            if (fill[SYNC_STAGES-1] && load_s)
                armed <= 1'b1;
        end
    end

    always_comb begin
        s16_rise   = rx_sr[7] & ~prev_sclk16;
        l1595_fall = prev_ld1595 & ~rx_sr[6];
        l595_rise  = rx_sr[5] & ~prev_ld595;
        ch_shift   = ch_sr;
        if (s16_rise) begin
            for (int i = 0; i < 8; i++)
                ch_shift[i] = {ch_sr[i][14:0], rx_sr[15-i]};
        end
        ch8_next = '0;
        for (int i = 0; i < 8; i++)
            ch8_next[8*i +: 8] = ch_shift[i][7:0];
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rx_sr           <= '0;
            bit_cnt         <= '0;
            ch_sr           <= '0;
            prev_sclk16     <= 1'b0;
            prev_ld1595     <= 1'b1;
            prev_ld595      <= 1'b0;
            bus.word_valid  <= 1'b0;
            bus.word_data   <= '0;
            bus.ch16_data   <= '0;
            bus.upd1595     <= 1'b0;
            bus.ch8_data    <= '0;
            bus.upd595      <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.pattern_err <= 1'b0;
        end else begin
            bus.word_valid <= 1'b0;
            bus.upd1595    <= 1'b0;
            bus.upd595     <= 1'b0;
            // Error sets further down override this clear.
            if (bus.clr_err) begin
                bus.frame_err   <= 1'b0;
                bus.pattern_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (load_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_sr <= {rx_sr[14:0], sdo_s};
                        if (bit_cnt != 5'd17)
                            bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (load_rise)
                        state <= CHECK;
                end
                CHECK: begin
                    if (bit_cnt != 5'd16) begin
                        bus.frame_err <= 1'b1;
                        state         <= IDLE;
                    end else if (rx_sr[4:0] != TAIL_PAT) begin
                        bus.pattern_err <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        bus.word_data  <= rx_sr;
                        bus.word_valid <= 1'b1;
                        state          <= DECODE;
                    end
                end
                DECODE: begin
                    ch_sr <= ch_shift;
                    if (l1595_fall) begin
                        bus.ch16_data <= ch_shift;
                        bus.upd1595   <= 1'b1;
                    end
                    if (l595_rise) begin
                        bus.ch8_data <= ch8_next;
                        bus.upd595   <= 1'b1;
                    end
                    prev_sclk16 <= rx_sr[7];
                    prev_ld1595 <= rx_sr[6];
                    prev_ld595  <= rx_sr[5];
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
